// File: rtl/elevator_call_scheduler.sv
// SCAN-ordered elevator call scheduler: latches floor calls, offers one floor
// command at a time to the car controller and times the door dwell on arrival.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  arrive,
  input  logic                  cmd_ready,
  output logic                  cmd_valid,
  output logic [FLOOR_W-1:0]    cmd_floor,
  output logic                  door_open,
  output logic                  direction,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam int CNT_W = (DOOR_CYCLES < 2) ? 1 : $clog2(DOOR_CYCLES + 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DISPATCH = 2'd1;
  localparam logic [1:0] TRAVEL   = 2'd2;
  localparam logic [1:0] DOOR     = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [NUM_FLOORS-1:0] pending_reg, pending_next;
  logic [FLOOR_W-1:0]    cmd_floor_reg, cmd_floor_next;
  logic                  dir_reg, dir_next;
  logic [CNT_W-1:0]      door_cnt_reg, door_cnt_next;

  logic [NUM_FLOORS-1:0] car_onehot, cmd_onehot, above_mask, below_mask;
  logic [NUM_FLOORS-1:0] pend_above, pend_below, set_mask, clear_mask;
  logic [FLOOR_W-1:0]    lowest_above, highest_below, target;
  logic                  target_up, here_hit, call_here;

  // Per-floor decode of the car position and the committed target.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign car_onehot[gi] = (car_floor == FLOOR_W'(gi));
      assign cmd_onehot[gi] = (cmd_floor_reg == FLOOR_W'(gi));
      assign above_mask[gi] = (FLOOR_W'(gi) > car_floor);
      assign below_mask[gi] = (FLOOR_W'(gi) < car_floor);
    end
  endgenerate

  assign pend_above = pending_reg & above_mask;
  assign pend_below = pending_reg & below_mask;
  assign here_hit   = |(pending_reg & car_onehot);
  assign call_here  = |(call_req & car_onehot);

  // Nearest pending floor on each side of the car.
  always_comb begin
    lowest_above = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pend_above[i]) lowest_above = FLOOR_W'(i);
    end
    highest_below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend_below[i]) highest_below = FLOOR_W'(i);
    end
  end

  // Keep sweeping in the current direction; reverse only when nothing is ahead.
  always_comb begin
    target    = highest_below;
    target_up = 1'b0;
    if (dir_reg) begin
      if (|pend_above) begin
        target    = lowest_above;
        target_up = 1'b1;
      end
    end else if (!(|pend_below)) begin
      target    = lowest_above;
      target_up = 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cmd_floor_next = cmd_floor_reg;
    dir_next       = dir_reg;
    door_cnt_next  = door_cnt_reg;
    set_mask       = call_req;
    clear_mask     = '0;
    case (state_reg)
      IDLE: begin
        if (here_hit) begin
          state_next    = DOOR;
          clear_mask    = car_onehot;
          door_cnt_next = DOOR_LOAD;
        end else if (|pending_reg) begin
          state_next     = DISPATCH;
          cmd_floor_next = target;
          dir_next       = target_up;
        end
      end
      DISPATCH: begin
        if (cmd_ready) state_next = TRAVEL;
      end
      TRAVEL: begin
        // Intermediate floors are passed without stopping.
        if (arrive && (car_floor == cmd_floor_reg)) begin
          state_next    = DOOR;
          clear_mask    = cmd_onehot;
          door_cnt_next = DOOR_LOAD;
        end
      end
      DOOR: begin
        // A call at the open door holds it open instead of queueing a new trip.
        set_mask = call_req & ~car_onehot;
        if (call_here) begin
          door_cnt_next = DOOR_LOAD;
        end else if (door_cnt_reg == CNT_ONE) begin
          state_next    = IDLE;
          door_cnt_next = '0;
        end else begin
          door_cnt_next = door_cnt_reg - CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
    pending_next = (pending_reg | set_mask) & ~clear_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      cmd_floor_reg <= '0;
      dir_reg       <= 1'b1;
      door_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      cmd_floor_reg <= cmd_floor_next;
      dir_reg       <= dir_next;
      door_cnt_reg  <= door_cnt_next;
    end
  end

  assign cmd_valid = (state_reg == DISPATCH);
  assign door_open = (state_reg == DOOR);
  assign busy      = (state_reg != IDLE);
  assign cmd_floor = cmd_floor_reg;
  assign direction = dir_reg;
  assign pending   = pending_reg;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: SCAN ordering, door dwell and
// hold, stalled dispatch and asynchronous reset, with hand-computed expectations.
module tb_elevator_call_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] call_req;
  logic [1:0] car_floor;
  logic       arrive;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_floor;
  logic       door_open;
  logic       direction;
  logic [3:0] pending;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  elevator_call_scheduler #(
    .NUM_FLOORS (4),
    .FLOOR_W    (2),
    .DOOR_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .call_req (call_req),
    .car_floor(car_floor),
    .arrive   (arrive),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_floor(cmd_floor),
    .door_open(door_open),
    .direction(direction),
    .pending  (pending),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; call_req = '0; car_floor = 2'd0; arrive = 1'b0; cmd_ready = 1'b0;
    step(); step();
    n_checks++;
    if ({pending, cmd_valid, cmd_floor, door_open, direction, busy} !== {4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_state got=%b exp=%b", {pending, cmd_valid, cmd_floor, door_open, direction, busy},
               {4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0});
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({pending, cmd_valid, busy, direction} !== {4'b0000, 1'b0, 1'b0, 1'b1})
        $display("FAIL idle_hold cycle=%0d got=%b exp=%b", i, {pending, cmd_valid, busy, direction}, 7'b0000001);
      else n_pass++;
    end
  endtask

  task automatic test_single_call();
    int cnt;
    car_floor = 2'd0; cmd_ready = 1'b1; call_req = 4'b1000;
    step();
    call_req = '0;
    n_checks++;
    if ({pending, cmd_valid} !== {4'b1000, 1'b0})
      $display("FAIL call_latch got=%b exp=%b", {pending, cmd_valid}, 5'b10000);
    else n_pass++;
    step();
    n_checks++;
    if ({cmd_valid, cmd_floor, direction} !== {1'b1, 2'd3, 1'b1})
      $display("FAIL dispatch_up got=%b exp=%b", {cmd_valid, cmd_floor, direction}, 4'b1111);
    else n_pass++;
    step();
    n_checks++;
    if ({cmd_valid, busy} !== {1'b0, 1'b1})
      $display("FAIL travel_entry got=%b exp=%b", {cmd_valid, busy}, 2'b01);
    else n_pass++;
    for (int f = 1; f <= 2; f++) begin
      arrive = 1'b1; car_floor = 2'(f);
      step();
      arrive = 1'b0;
      n_checks++;
      if ({busy, door_open, cmd_valid} !== {1'b1, 1'b0, 1'b0})
        $display("FAIL pass_floor%0d got=%b exp=%b", f, {busy, door_open, cmd_valid}, 3'b100);
      else n_pass++;
    end
    arrive = 1'b1; car_floor = 2'd3;
    step();
    arrive = 1'b0;
    cnt = 0;
    while (door_open && cnt < 20) begin
      cnt++;
      step();
    end
    n_checks++;
    if (cnt !== 4) $display("FAIL door_len_f3 got=%0d exp=%0d", cnt, 4);
    else n_pass++;
    n_checks++;
    if ({pending, busy} !== {4'b0000, 1'b0})
      $display("FAIL served_f3 got=%b exp=%b", {pending, busy}, 5'b00000);
    else n_pass++;
  endtask

  task automatic test_scan_reverse();
    int cnt;
    car_floor = 2'd1; cmd_ready = 1'b1; call_req = 4'b1001;
    step();
    call_req = '0;
    n_checks++;
    if (pending !== 4'b1001) $display("FAIL dual_latch got=%b exp=%b", pending, 4'b1001);
    else n_pass++;
    step();
    n_checks++;
    if ({cmd_valid, cmd_floor, direction} !== {1'b1, 2'd3, 1'b1})
      $display("FAIL scan_first got=%b exp=%b", {cmd_valid, cmd_floor, direction}, 4'b1111);
    else n_pass++;
    step();
    arrive = 1'b1; car_floor = 2'd3;
    step();
    arrive = 1'b0;
    cnt = 0;
    while (door_open && cnt < 20) begin
      cnt++;
      step();
    end
    n_checks++;
    if ({cnt[3:0], pending} !== {4'd4, 4'b0001})
      $display("FAIL scan_serve3 got=%b exp=%b", {cnt[3:0], pending}, 8'b01000001);
    else n_pass++;
    cnt = 0;
    while (!cmd_valid && cnt < 10) begin
      cnt++;
      step();
    end
    n_checks++;
    if ({cmd_valid, cmd_floor, direction} !== {1'b1, 2'd0, 1'b0})
      $display("FAIL scan_reverse got=%b exp=%b", {cmd_valid, cmd_floor, direction}, 4'b1000);
    else n_pass++;
    step();
    arrive = 1'b1; car_floor = 2'd0;
    step();
    arrive = 1'b0;
    cnt = 0;
    while (door_open && cnt < 20) begin
      cnt++;
      step();
    end
    n_checks++;
    if ({cnt[3:0], pending, busy} !== {4'd4, 4'b0000, 1'b0})
      $display("FAIL scan_serve0 got=%b exp=%b", {cnt[3:0], pending, busy}, 9'b010000000);
    else n_pass++;
  endtask

  task automatic test_call_here();
    int cnt;
    car_floor = 2'd2; call_req = 4'b0100;
    step();
    call_req = '0;
    n_checks++;
    if ({pending, door_open} !== {4'b0100, 1'b0})
      $display("FAIL here_latch got=%b exp=%b", {pending, door_open}, 5'b01000);
    else n_pass++;
    step();
    n_checks++;
    if ({door_open, cmd_valid, pending} !== {1'b1, 1'b0, 4'b0000})
      $display("FAIL here_open got=%b exp=%b", {door_open, cmd_valid, pending}, 6'b100000);
    else n_pass++;
    cnt = 0;
    while (door_open && cnt < 20) begin
      cnt++;
      step();
    end
    n_checks++;
    if ({cnt[3:0], busy, cmd_valid} !== {4'd4, 1'b0, 1'b0})
      $display("FAIL here_len got=%b exp=%b", {cnt[3:0], busy, cmd_valid}, 6'b010000);
    else n_pass++;
  endtask

  task automatic test_door_hold();
    int cnt;
    car_floor = 2'd2; call_req = 4'b0100;
    step();
    call_req = '0;
    step();
    cnt = 0;
    while (door_open && cnt < 30) begin
      cnt++;
      call_req = (cnt == 3) ? 4'b0100 : 4'b0000;
      step();
      n_checks++;
      if (pending !== 4'b0000) $display("FAIL hold_pending cycle=%0d got=%b exp=%b", cnt, pending, 4'b0000);
      else n_pass++;
    end
    call_req = '0;
    n_checks++;
    if (cnt !== 7) $display("FAIL hold_len got=%0d exp=%0d", cnt, 7);
    else n_pass++;
    n_checks++;
    if ({busy, pending} !== {1'b0, 4'b0000})
      $display("FAIL hold_exit got=%b exp=%b", {busy, pending}, 5'b00000);
    else n_pass++;
  endtask

  task automatic test_stall_reset();
    car_floor = 2'd2; cmd_ready = 1'b0; call_req = 4'b0010;
    step();
    call_req = '0;
    step();
    n_checks++;
    if ({cmd_valid, cmd_floor, direction} !== {1'b1, 2'd1, 1'b0})
      $display("FAIL stall_offer got=%b exp=%b", {cmd_valid, cmd_floor, direction}, 4'b1010);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      call_req = (i == 1) ? 4'b1000 : 4'b0000;
      step();
      n_checks++;
      if ({cmd_valid, cmd_floor} !== {1'b1, 2'd1})
        $display("FAIL stall_hold cycle=%0d got=%b exp=%b", i, {cmd_valid, cmd_floor}, 3'b101);
      else n_pass++;
    end
    call_req = '0;
    n_checks++;
    if (pending !== 4'b1010) $display("FAIL stall_pending got=%b exp=%b", pending, 4'b1010);
    else n_pass++;
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({cmd_valid, pending, busy, direction} !== {1'b0, 4'b0000, 1'b0, 1'b1})
      $display("FAIL async_reset got=%b exp=%b", {cmd_valid, pending, busy, direction}, 7'b0000001);
    else n_pass++;
    step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({cmd_valid, pending, busy} !== {1'b0, 4'b0000, 1'b0})
      $display("FAIL post_reset got=%b exp=%b", {cmd_valid, pending, busy}, 6'b000000);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan_reverse();
    test_call_here();
    test_door_hold();
    test_stall_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Latches floor call requests and picks the next floor to serve using SCAN ordering: keep the current direction, reverse only when nothing is left ahead.
- Commands the existing elevator car controller through a valid/ready floor-command handshake.
- Consumes the car's arrival reports and times the door-open dwell at each served floor.
- Sits between the call-button synchronisers and elevator_controller.

Parameters:
- NUM_FLOORS, 4: number of served floors (2..16).
- FLOOR_W, 2: width of floor indices; must be at least clog2(NUM_FLOORS).
- DOOR_CYCLES, 4: number of cycles door_open stays high per service (at least 1).

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset).
- call_req, input, NUM_FLOORS: one bit per floor; each high cycle registers a call for that floor.
- car_floor, input, FLOOR_W: current floor reported by the car controller.
- arrive, input, 1: one-cycle pulse from the car on reaching any floor; car_floor is valid in that cycle.
- cmd_ready, input, 1: car controller accepts a command.
- cmd_valid, output, 1: a floor command is offered.
- cmd_floor, output, FLOOR_W: target floor of the offered command.
- door_open, output, 1: door is open at car_floor.
- direction, output, 1: 1 = up, 0 = down.
- pending, output, NUM_FLOORS: registered outstanding calls.
- busy, output, 1: state is not IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; pending = 0; cmd_valid = 0; cmd_floor = 0; door_open = 0; direction = 1; busy = 0; door counter = 0.
  - Reset mid-operation aborts immediately. cmd_valid drops without waiting for cmd_ready.
- pending register:
  - pending[k] <= pending[k] | call_req[k] every cycle, except for the clear rules below.
  - The effect is visible one cycle after call_req.
- States: IDLE, DISPATCH, TRAVEL, DOOR.
- IDLE:
  - If pending[car_floor] = 1: go to DOOR, clear pending[car_floor], load counter = DOOR_CYCLES.
  - Else if pending is non-zero: select target, register it into cmd_floor, go to DISPATCH. direction is updated to the direction of the chosen target.
  - Else stay in IDLE.
- Target selection (combinational on pending and car_floor):
  - direction = 1: the lowest pending floor above car_floor; if none, the highest pending floor below car_floor.
  - direction = 0: mirror of the above.
- DISPATCH:
  - cmd_valid = 1; cmd_floor is held stable until handshake.
  - On cmd_valid & cmd_ready: go to TRAVEL and drop cmd_valid the next cycle. The handshake takes 1 cycle minimum.
  - New calls do not retarget an offered command.
- TRAVEL:
  - Wait for arrive.
  - arrive with car_floor != cmd_floor (passing an intermediate floor): ignored, stay in TRAVEL. A pending call at that floor stays pending; there is no opportunistic stop.
  - arrive with car_floor = cmd_floor: go to DOOR, clear pending[cmd_floor], load counter = DOOR_CYCLES.
- DOOR:
  - door_open = 1 for exactly DOOR_CYCLES cycles. The counter decrements each cycle; at 1, go to IDLE.
  - call_req[car_floor] during DOOR is not latched; it reloads the counter to DOOR_CYCLES (door held open).
- Same-cycle set and clear on one floor: the clear wins, and the call is considered served.
- Simultaneous calls to several floors: all are latched in the same cycle; the selection rule orders service.
- Latency: call_req high at edge E0 → pending set at E0 → DISPATCH with cmd_valid = 1 after E1 (car idle at another floor).
- cmd_valid never asserts while door_open = 1.

Test Plan:
- After reset release, car_floor = 0 with no calls: pending = 0, cmd_valid = 0, busy = 0, direction = 1 held for 20 cycles.
- car_floor = 0, pulse call_req = 4'b1000, cmd_ready = 1: cmd_valid high 2 cycles after the pulse with cmd_floor = 3. After arrive with car_floor = 1 and 2: still in TRAVEL. After arrive with car_floor = 3: door_open high exactly 4 cycles, pending = 0, back to IDLE.
- car_floor = 1, direction = 1, call_req = 4'b1001 in the same cycle: first cmd_floor = 3. After service, next cmd_floor = 0 with direction = 0.
- Call at the current floor while idle (car_floor = 2, call_req = 4'b0100): no command issued; door_open for 4 cycles; pending[2] clears.
- During DOOR at floor 2, pulse call_req[2] on the 3rd door cycle: door_open extends to 3 + 4 = 7 cycles total; pending[2] stays 0.
- cmd_ready held 0 for 5 cycles in DISPATCH: cmd_valid and cmd_floor stay stable. Assert reset = 0 mid-DISPATCH: cmd_valid = 0 and pending = 0 immediately, without waiting for a clock edge.
